// File: rtl/cnn_pkg.sv
// Shared CNN layer-memory constants: port widths, csel encodings, layer depths,
// and the csel/address range check used by the memory arbiter.
package cnn_pkg;

   localparam int AW = 12;
   localparam int DW = 20;
   localparam int SW = 3;

   localparam int L0_DEPTH = 4096;
   localparam int L1_DEPTH = 1024;

   typedef enum logic [SW-1:0] {
      CSEL_NONE  = 3'd0,
      CSEL_L0_K0 = 3'd1,
      CSEL_L0_K1 = 3'd2,
      CSEL_L1_K0 = 3'd3,
      CSEL_L1_K1 = 3'd4,
      CSEL_L2    = 3'd5
   } csel_e;

   // Layer-1 banks are only L1_DEPTH deep; every other valid select spans the full address range.
   function automatic logic csel_range_ok(input logic [SW-1:0] s, input logic [AW-1:0] a);
      logic ok;
      ok = (s != CSEL_NONE) && (s <= CSEL_L2);
      if ((s == CSEL_L1_K0) || (s == CSEL_L1_K1)) ok = ok && (int'(a) < L1_DEPTH);
      return ok;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin one-hot picker with a lock-owner override.
module rr_pick #(
   parameter int NREQ = 3,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   input  logic            force_en,
   input  logic [PW-1:0]   force_idx,
   output logic [NREQ-1:0] gnt
);

   always_comb begin
      int idx;
      // NOTE: every output gets a default first so no latch is inferred.
      gnt = '0;
      idx = 0;
      if (force_en && req[force_idx]) begin
         gnt[force_idx] = 1'b1;
      end else begin
         // Scan starts one past the last winner, so the last winner has lowest priority.
         for (int i = 1; i <= NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if ((gnt == '0) && req[PW'(idx)]) gnt[PW'(idx)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter sharing the layer-memory port among the CNN engines.
// Optional LMA_RANGE_CHK_EN adds a sticky err output and drops out-of-range accesses.
module layer_mem_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = cnn_pkg::AW,
   parameter int DW   = cnn_pkg::DW,
   parameter int SW   = cnn_pkg::SW
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ*SW-1:0] sel,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic               idle,
   output logic [SW-1:0]      csel,
   output logic               cwr,
   output logic [AW-1:0]      caddr_wr,
   output logic [DW-1:0]      cdata_wr,
   output logic               crd,
   output logic [AW-1:0]      caddr_rd,
   input  logic [DW-1:0]      cdata_rd
`ifdef LMA_RANGE_CHK_EN
   , output logic             err
`endif
);

   import cnn_pkg::*;

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   owner;
   logic            owner_vld;
   logic [NREQ-1:0] pick_gnt;
   logic [NREQ-1:0] rd_tag;

   logic            xfer;
   logic            issue;
   logic [PW-1:0]   k;
   logic            k_we;
   logic            k_lock;
   logic [SW-1:0]   k_sel;
   logic [AW-1:0]   k_addr;
   logic [DW-1:0]   k_wdata;

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req       (req),
      .ptr       (rr_ptr),
      .force_en  (owner_vld),
      .force_idx (owner),
      .gnt       (pick_gnt)
   );

   // Grant is combinational, so it must also be forced low while reset is held.
   assign gnt  = pick_gnt & {NREQ{reset_n}};
   assign xfer = |(req & gnt);

   always_comb begin
      k       = '0;
      k_we    = 1'b0;
      k_lock  = 1'b0;
      k_sel   = '0;
      k_addr  = '0;
      k_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            k       = PW'(i);
            k_we    = we[i];
            k_lock  = lock[i];
            k_sel   = sel[i*SW +: SW];
            k_addr  = addr[i*AW +: AW];
            k_wdata = wdata[i*DW +: DW];
         end
      end
   end

`ifdef LMA_RANGE_CHK_EN
   logic range_bad;
   assign range_bad = xfer & ~csel_range_ok(k_sel, k_addr);
   assign issue     = xfer & ~range_bad;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       err <= 1'b0;
      else if (range_bad) err <= 1'b1;
   end
`else
   assign issue = xfer;
`endif

   // Arbitration state: round-robin pointer and lock owner.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr    <= PW'(NREQ - 1);
         owner     <= '0;
         owner_vld <= 1'b0;
      end else if (xfer) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         rr_ptr    <= k;
         owner     <= k;
         owner_vld <= k_lock;
      end else if (owner_vld && !req[owner]) begin
         owner_vld <= 1'b0;
      end
   end

   // Command stage (t+1) and read-return stage (t+2).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cwr      <= 1'b0;
         crd      <= 1'b0;
         csel     <= '0;
         caddr_wr <= '0;
         cdata_wr <= '0;
         caddr_rd <= '0;
         rd_tag   <= '0;
         rvalid   <= '0;
         rdata    <= '0;
      end else begin
         cwr <= issue & k_we;
         crd <= issue & ~k_we;
         if (issue) csel <= k_sel;
         if (issue && k_we) begin
            caddr_wr <= k_addr;
            cdata_wr <= k_wdata;
         end
         if (issue && !k_we) begin
            caddr_rd <= k_addr;
            rd_tag   <= gnt;
         end
         rvalid <= crd ? rd_tag : '0;
         if (crd) rdata <= cdata_rd;
      end
   end

   assign idle = ~|req & ~cwr & ~crd & ~|rvalid;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Scoreboard bench for layer_mem_arbiter: directed engine traffic, monitor-side checking.
// Define LMA_RANGE_CHK_EN for both DUT and bench to exercise the range-check build.
module tb_layer_mem_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 12;
   localparam int DW   = 20;
   localparam int SW   = 3;

   typedef struct packed {
      logic          we;
      logic          lock;
      logic [SW-1:0] sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } acc_t;

   typedef struct packed {
      int   idx;
      acc_t a;
      bit   issue;
      bit   chain;
   } exp_t;

   typedef struct packed {
      exp_t e;
      int   g;
   } cmd_t;

   logic              clk;
   logic              reset_n;
   logic [NREQ-1:0]   req, lock, we;
   logic [NREQ*SW-1:0] sel;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]   gnt, rvalid;
   logic [DW-1:0]     rdata, cdata_wr, cdata_rd;
   logic              idle, cwr, crd;
   logic [SW-1:0]     csel;
   logic [AW-1:0]     caddr_wr, caddr_rd;
`ifdef LMA_RANGE_CHK_EN
   logic              err;
`endif

   acc_t rq     [NREQ][$];
   acc_t shadow [NREQ][$];
   exp_t eg_q[$];
   cmd_t ec_q[$];
   cmd_t er_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_g = -10;
   logic [NREQ-1:0] took;
   exp_t mon_e;
   cmd_t mon_c;

   layer_mem_arbiter dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .lock     (lock),
      .we       (we),
      .sel      (sel),
      .addr     (addr),
      .wdata    (wdata),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .idle     (idle),
      .csel     (csel),
      .cwr      (cwr),
      .caddr_wr (caddr_wr),
      .cdata_wr (cdata_wr),
      .crd      (crd),
      .caddr_rd (caddr_rd),
      .cdata_rd (cdata_rd)
`ifdef LMA_RANGE_CHK_EN
      , .err    (err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: read data is a fixed function of select and address (sel 1, addr 040 -> 12345).
   function automatic logic [DW-1:0] data_fn(input logic [SW-1:0] s, input logic [AW-1:0] a);
      return {s, 5'b0, a} ^ 20'h12345 ^ 20'h20040;
   endfunction

   function automatic bit tb_bad(input logic [SW-1:0] s, input logic [AW-1:0] a);
`ifdef LMA_RANGE_CHK_EN
      return (s == 3'd0) || (s > 3'd5) || (((s == 3'd3) || (s == 3'd4)) && (a >= 12'd1024));
`else
      return (s === 3'bx) && (a === 12'bx);
`endif
   endfunction

   assign cdata_rd = crd ? data_fn(csel, caddr_rd) : '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic load(input int idx, input logic w, input logic lk, input logic [SW-1:0] s,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
      acc_t x;
      x = '{we: w, lock: lk, sel: s, addr: a, wdata: d};
      rq[idx].push_back(x);
      shadow[idx].push_back(x);
   endtask

   task automatic expect_next(input int idx, input bit chain);
      exp_t e;
      e.idx   = idx;
      e.a     = shadow[idx].pop_front();
      e.issue = !tb_bad(e.a.sel, e.a.addr);
      e.chain = chain;
      eg_q.push_back(e);
   endtask

   function automatic bit q_empty();
      bit r;
      r = (eg_q.size() == 0) && (ec_q.size() == 0) && (er_q.size() == 0);
      for (int i = 0; i < NREQ; i++) r = r && (rq[i].size() == 0);
      return r;
   endfunction

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (!(q_empty() && idle) && n < 60) begin
         @(negedge clk);
         #2;
         n++;
      end
      check({name, "_drained"}, {31'b0, q_empty()}, 1);
      check({name, "_idle"}, {31'b0, idle}, 1);
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_gnt"}, gnt, 0);
      check({name, "_rvalid"}, rvalid, 0);
      check({name, "_rdata"}, rdata, 0);
      check({name, "_csel"}, csel, 0);
      check({name, "_cwr"}, cwr, 0);
      check({name, "_crd"}, crd, 0);
      check({name, "_caddr_wr"}, caddr_wr, 0);
      check({name, "_caddr_rd"}, caddr_rd, 0);
      check({name, "_cdata_wr"}, cdata_wr, 0);
      check({name, "_idle"}, idle, 1);
`ifdef LMA_RANGE_CHK_EN
      check({name, "_err"}, err, 0);
`endif
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req     = '0;
      for (int i = 0; i < NREQ; i++) begin
         rq[i].delete();
         shadow[i].delete();
      end
      eg_q.delete();
      ec_q.delete();
      er_q.delete();
   endtask

   // Engine driver: holds each head-of-queue access until it has been granted.
   always begin
      @(negedge clk);
      took = req & gnt;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (took[i] && rq[i].size() > 0) rq[i].delete(0);
         req[i]  = (rq[i].size() > 0);
         if (rq[i].size() > 0) begin
            we[i]               = rq[i][0].we;
            lock[i]             = rq[i][0].lock;
            sel[i*SW +: SW]     = rq[i][0].sel;
            addr[i*AW +: AW]    = rq[i][0].addr;
            wdata[i*DW +: DW]   = rq[i][0].wdata;
         end
      end
   end

   // Monitor: pops and compares expected grants, commands and read returns.
   always @(negedge clk) begin
      if (reset_n) begin
         check("gnt_onehot", {31'b0, $onehot0(gnt)}, 1);
         check("gnt_without_req", gnt & ~req, 0);
         if ((req & gnt) != 0) begin
            if (eg_q.size() == 0) begin
               check("unexpected_grant", gnt, 0);
            end else begin
               mon_e = eg_q.pop_front();
               check("grant_idx", gnt, 32'(1) << mon_e.idx);
               if (mon_e.chain) check("grant_back_to_back", cyc, last_g + 1);
               if (mon_e.issue) ec_q.push_back('{e: mon_e, g: cyc});
            end
            last_g = cyc;
         end
         if (cwr || crd) begin
            if (ec_q.size() == 0) begin
               check("unexpected_cmd", {cwr, crd}, 0);
            end else begin
               mon_c = ec_q.pop_front();
               check("cmd_latency", cyc, mon_c.g + 1);
               check("cmd_cwr", cwr, mon_c.e.a.we);
               check("cmd_crd", crd, !mon_c.e.a.we);
               check("cmd_csel", csel, mon_c.e.a.sel);
               if (mon_c.e.a.we) begin
                  check("cmd_caddr_wr", caddr_wr, mon_c.e.a.addr);
                  check("cmd_cdata_wr", cdata_wr, mon_c.e.a.wdata);
               end else begin
                  check("cmd_caddr_rd", caddr_rd, mon_c.e.a.addr);
                  er_q.push_back(mon_c);
               end
            end
         end
         if (rvalid != 0) begin
            if (er_q.size() == 0) begin
               check("unexpected_rvalid", rvalid, 0);
            end else begin
               mon_c = er_q.pop_front();
               check("rvalid_tag", rvalid, 32'(1) << mon_c.e.idx);
               check("rdata", rdata, data_fn(mon_c.e.a.sel, mon_c.e.a.addr));
               check("read_latency", cyc, mon_c.g + 2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n;
      reset_n = 1'b0;
      req = '0; lock = '0; we = '0; sel = '0; addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1 check_reset_vals("por");
      @(posedge clk);
      #2 reset_n = 1'b1;

      // All three engines contend without lock: 0,1,2,0,1,2 back to back.
      load(0, 0, 0, 3'd1, 12'h001, 20'h0);
      load(0, 1, 0, 3'd2, 12'h002, 20'hAAAA0);
      load(1, 0, 0, 3'd3, 12'h3FF, 20'h0);
      load(1, 0, 0, 3'd5, 12'h010, 20'h0);
      load(2, 1, 0, 3'd4, 12'h123, 20'h55555);
      load(2, 0, 0, 3'd2, 12'hFFF, 20'h0);
      expect_next(0, 0); expect_next(1, 1); expect_next(2, 1);
      expect_next(0, 1); expect_next(1, 1); expect_next(2, 1);
      @(posedge clk);
      @(negedge clk);
      #1 check("idle_busy", idle, 0);
      wait_drain("rr_all");

      // Single read from requester 1.
      load(1, 0, 0, 3'd1, 12'h040, 20'h0);
      expect_next(1, 0);
      wait_drain("single_read");

      // Single write from requester 0 moves the pointer to 0.
      load(0, 1, 0, 3'd5, 12'h010, 20'h00111);
      expect_next(0, 0);
      wait_drain("single_write");

      // Locked pool window: requester 1 owns five accesses, then 2, then 0.
      load(1, 0, 1, 3'd2, 12'h100, 20'h0);
      load(1, 0, 1, 3'd2, 12'h101, 20'h0);
      load(1, 0, 1, 3'd2, 12'h140, 20'h0);
      load(1, 0, 1, 3'd2, 12'h141, 20'h0);
      load(1, 1, 0, 3'd3, 12'h050, 20'h0BEEF);
      load(0, 0, 0, 3'd1, 12'h7FF, 20'h0);
      load(2, 0, 0, 3'd5, 12'h200, 20'h0);
      expect_next(1, 0);
      for (int i = 0; i < 4; i++) expect_next(1, 1);
      expect_next(2, 1); expect_next(0, 1);
      wait_drain("lock");

      // Owner drops req while locked: waiting requester 0 wins the next cycle.
      load(2, 0, 1, 3'd1, 12'h300, 20'h0);
      load(0, 0, 0, 3'd2, 12'h301, 20'h0);
      expect_next(2, 0); expect_next(0, 1);
      wait_drain("abandon_wait");

      // Owner drops req with nobody waiting: the stale lock must not favour it later.
      load(2, 0, 1, 3'd4, 12'h0FF, 20'h0);
      expect_next(2, 0);
      wait_drain("abandon_alone");
      repeat (2) @(negedge clk);
      load(1, 0, 0, 3'd1, 12'h011, 20'h0);
      load(2, 0, 0, 3'd1, 12'h022, 20'h0);
      expect_next(1, 0); expect_next(2, 1);
      wait_drain("abandon_release");

      // Reset while a read is in flight.
      load(0, 0, 0, 3'd2, 12'h444, 20'h0);
      expect_next(0, 0);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!crd && n < 20);
      check("mid_crd_seen", crd, 1);
      do_reset();
      #1 check_reset_vals("mid");
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      load(2, 0, 0, 3'd1, 12'h555, 20'h0);
      load(0, 0, 0, 3'd3, 12'h066, 20'h0);
      expect_next(0, 0); expect_next(2, 1);
      wait_drain("after_reset");

      // Out-of-range accesses (dropped only in the range-check build), then a legal edge address.
`ifdef LMA_RANGE_CHK_EN
      check("err_before", err, 0);
`endif
      load(0, 1, 0, 3'd3, 12'd1024, 20'h00F0F);
      load(1, 0, 0, 3'd0, 12'h005, 20'h0);
      load(2, 0, 0, 3'd6, 12'h006, 20'h0);
      load(0, 0, 0, 3'd4, 12'd1023, 20'h0);
      expect_next(0, 0); expect_next(1, 1); expect_next(2, 1); expect_next(0, 1);
      wait_drain("range");
`ifdef LMA_RANGE_CHK_EN
      check("err_set", err, 1);
      repeat (3) @(negedge clk);
      check("err_sticky", err, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/layer_mem_arbiter.md
Name: layer_mem_arbiter

Overview:
- Shares the single layer-memory port (csel / caddr_rd / caddr_wr / cwr / crd) among the CNN engines: conv writer, max-pool reader/writer, and flatten reader/writer.
- Each engine issues a one-access-per-cycle request with a full payload. The arbiter grants round-robin, registers the memory command, and returns read data tagged to the requester.
- A lock input keeps a multi-access sequence (e.g. a 2x2 pool window plus its write) atomic.

Parameters:
- NREQ, 3, number of requesters
- AW, 12, memory address width
- DW, 20, data width
- SW, 3, csel width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester access request; must be held with a stable payload until granted
- lock  in  NREQ  requester wants to keep ownership after this access
- we  in  NREQ  1 = write, 0 = read
- sel  in  NREQ*SW  per-requester csel, packed; requester i uses [i*SW +: SW]
- addr  in  NREQ*AW  per-requester address, packed
- wdata  in  NREQ*DW  per-requester write data, packed
- gnt  out  NREQ  combinational one-hot grant; the access transfers at the clock edge where req[i]&gnt[i]
- rvalid  out  NREQ  one-hot read-return strobe
- rdata  out  DW  read data, shared by all requesters, qualified by rvalid
- idle  out  1  no request pending and no command or return in flight
- csel  out  SW  memory select, registered
- cwr  out  1  memory write strobe, registered
- caddr_wr  out  AW  memory write address, registered
- cdata_wr  out  DW  memory write data, registered
- crd  out  1  memory read strobe, registered
- caddr_rd  out  AW  memory read address, registered
- cdata_rd  in  DW  memory read data; valid during the cycle crd is high

Behaviour:
- Reset values (reset_n low, asynchronous):
  - gnt=0, rvalid=0, rdata=0, csel=0, cwr=0, crd=0, caddr_wr=0, caddr_rd=0, cdata_wr=0, idle=1.
  - rr_ptr=NREQ-1, so requester 0 has top priority first.
  - lock owner cleared.
- Arbitration (combinational, cycle t):
  - If a lock owner exists and req[owner]=1: gnt=onehot(owner), other requesters blocked.
  - Otherwise: first i with req[i]=1 scanning from rr_ptr+1 modulo NREQ.
  - At most one gnt bit is ever high. gnt[i] never asserts without req[i].
- Transfer at edge t with req[k]&gnt[k]:
  - rr_ptr<=k.
  - If lock[k]=1, owner<=k; else owner cleared.
  - If req[owner] is low while an owner exists, owner clears at that edge.
- Command stage (cycle t+1), write transfer:
  - cwr=1, caddr_wr=addr[k], cdata_wr=wdata[k], csel=sel[k], crd=0.
  - caddr_rd is held.
- Command stage (cycle t+1), read transfer:
  - crd=1, caddr_rd=addr[k], csel=sel[k], cwr=0.
  - caddr_wr and cdata_wr are held.
- No transfer:
  - cwr=0, crd=0 next cycle; csel and addresses hold their last values.
- Read return:
  - cdata_rd is sampled at the end of t+1.
  - rdata<=cdata_rd and rvalid<=onehot(k) in cycle t+2. Latency from grant edge to rvalid is 2 cycles.
- Throughput: one access per cycle. Back-to-back reads from different requesters pipeline with no bubble; rvalid follows grant order.
- A write immediately after a read to the same address needs no hazard handling; the memory orders them by cycle.
- idle = (req==0) & no command in the t+1 stage & no rvalid pending.
- Reset mid-operation: any in-flight command and return is discarded, and outputs take their reset values immediately.

Optional Feature:
- Macro: LMA_RANGE_CHK_EN.
- With the macro:
  - Adds output err (1 bit, sticky, reset 0).
  - A transferred access with csel==0, csel>5, or (csel in {3,4} and addr>1023) is still granted, but no cwr/crd is issued and no rvalid is returned.
  - err sets in t+1 and is cleared only by reset.
- Without the macro: no err port; every transferred access is issued unchanged.

Decomposition:
- Shared package cnn_pkg holds:
  - width constants AW=12, DW=20, SW=3;
  - csel encodings CSEL_L0_K0=1, CSEL_L0_K1=2, CSEL_L1_K0=3, CSEL_L1_K1=4, CSEL_L2=5;
  - layer depths 4096 and 1024.
- One sub-module, rr_pick: a combinational round-robin one-hot picker taking req, ptr and a force-owner input.

Test Plan:
- Single read: req[1], addr=12'h040, sel=1, cdata_rd=20'h12345 -> gnt[1] the same cycle; crd=1, caddr_rd=040, csel=1 one cycle later; rvalid=3'b010, rdata=12345 two cycles later.
- All three requesters request continuously (no lock) -> gnt sequence 0,1,2,0,1,2; one memory access per cycle; rvalid order matches grant order.
- Lock atomicity: req1 does 4 reads with lock=1 and then a write with lock=0, while req0 and req2 also request -> gnt[1] for 5 consecutive cycles; the next grant goes to req2.
- Lock abandon: owner drops req while lock=1 -> lock released at that edge; a waiting requester is granted the next cycle.
- Reset asserted while a read is in flight -> outputs go to reset values immediately; no rvalid after release; the first grant after reset goes to req0.
- LMA_RANGE_CHK_EN: write with csel=3, addr=1024 -> gnt pulses, no cwr, err=1 and stays 1.
